// File: rtl/video_timing_pkg.sv
// Shared timing presets, the packed sync bundle and small helpers used by the
// video timing generator and its pixel clock-enable sub-module.
package video_timing_pkg;

    // 640x480 @ 60 Hz, 25 MHz nominal pixel rate
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    // 1280x720 @ 60 Hz, 74.25 MHz nominal pixel rate
    localparam int HD_H_ACTIVE  = 1280;
    localparam int HD_H_FRONT   = 110;
    localparam int HD_H_SYNC    = 40;
    localparam int HD_H_BACK    = 220;
    localparam int HD_V_ACTIVE  = 720;
    localparam int HD_V_FRONT   = 5;
    localparam int HD_V_SYNC    = 5;
    localparam int HD_V_BACK    = 20;

    typedef struct packed {
        logic display_on;
        logic vsync;
        logic hsync;
    } sync_t;

    function automatic int h_total(input int active, input int front,
                                   input int sync, input int back);
        return active + front + sync + back;
    endfunction

    function automatic int v_total(input int active, input int front,
                                   input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Pin level for a sync pulse: pol=1 drives the active level high.
    function automatic logic sync_level(input logic active, input int pol);
        return (pol != 0) ? active : ~active;
    endfunction

    function automatic sync_t sync_idle(input int hpol, input int vpol);
        sync_t s;
        s.display_on = 1'b0;
        s.vsync      = sync_level(1'b0, vpol);
        s.hsync      = sync_level(1'b0, hpol);
        return s;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Bundle of timing outputs from the generator to the pixel pipeline / DVI
// transmitter.
interface video_timing_gen_if #(
    parameter int w_x     = 10,
    parameter int w_y     = 10,
    parameter int w_frame = 8
);
    logic               pixel_ce;
    logic               pixel_clk;
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic               line_start;
    logic               frame_start;
    logic [w_frame-1:0] frame_count;

    modport master (
        output pixel_ce,
        output pixel_clk,
        output x,
        output y,
        output hsync,
        output vsync,
        output display_on,
        output line_start,
        output frame_start,
        output frame_count
    );

    modport slave (
        input pixel_ce,
        input pixel_clk,
        input x,
        input y,
        input hsync,
        input vsync,
        input display_on,
        input line_start,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/pixel_ce_gen.sv
// Phase-accumulator pixel clock-enable: emits one tick per pixel for any
// pixel_mhz <= clk_mhz ratio, plus a registered pixel clock.
module pixel_ce_gen #(
    parameter int clk_mhz   = 125,
    parameter int pixel_mhz = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o,
    output logic pixel_ce_o,
    output logic pixel_clk_o
);
    // Sum of acc (< clk_mhz) and pixel_mhz (<= clk_mhz) stays below 2*clk_mhz.
    localparam int W_ACC = $clog2(2 * clk_mhz) + 1;
    localparam logic [W_ACC-1:0] PIX_STEP = W_ACC'(pixel_mhz);
    localparam logic [W_ACC-1:0] CLK_MOD  = W_ACC'(clk_mhz);
    localparam logic [W_ACC-1:0] HALF_MOD = W_ACC'(clk_mhz / 2);

    logic [W_ACC-1:0] acc_q;
    logic [W_ACC-1:0] acc_d;
    logic [W_ACC-1:0] acc_sum;
    logic             tick;
    logic             pixel_ce_q;
    logic             pixel_clk_q;

    always_comb begin
        acc_sum = acc_q + PIX_STEP;
        acc_d   = acc_sum;
        tick    = 1'b0;
        if (acc_sum >= CLK_MOD) begin
            acc_d = acc_sum - CLK_MOD;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            pixel_ce_q  <= 1'b0;
            pixel_clk_q <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            pixel_ce_q  <= tick;
            pixel_clk_q <= (acc_d < HALF_MOD);
        end
    end

    // tick_o is the combinational advance strobe; pixel_ce_o lands with the
    // counter update it caused.
    assign tick_o      = tick;
    assign pixel_ce_o  = pixel_ce_q;
    assign pixel_clk_o = pixel_clk_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: x/y counters, sync/DE regions,
// line/frame strobes and frame counter, advanced by a fractional pixel enable.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int clk_mhz    = 125,
    parameter int pixel_mhz  = 25,
    parameter int h_active   = VGA_H_ACTIVE,
    parameter int h_front    = VGA_H_FRONT,
    parameter int h_sync     = VGA_H_SYNC,
    parameter int h_back     = VGA_H_BACK,
    parameter int v_active   = VGA_V_ACTIVE,
    parameter int v_front    = VGA_V_FRONT,
    parameter int v_sync     = VGA_V_SYNC,
    parameter int v_back     = VGA_V_BACK,
    parameter int hsync_pol  = 0,
    parameter int vsync_pol  = 0,
    parameter int sync_delay = 0,
    parameter int w_frame    = 8,
    parameter int w_x        = $clog2(h_total(h_active, h_front, h_sync, h_back)),
    parameter int w_y        = $clog2(v_total(v_active, v_front, v_sync, v_back))
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vid_o
);
    localparam int H_TOTAL  = h_total(h_active, h_front, h_sync, h_back);
    localparam int V_TOTAL  = v_total(v_active, v_front, v_sync, v_back);
    localparam int HS_START = h_active + h_front;
    localparam int HS_STOP  = h_active + h_front + h_sync;
    localparam int VS_START = v_active + v_front;
    localparam int VS_STOP  = v_active + v_front + v_sync;
    localparam logic [w_x-1:0] X_LAST = w_x'(H_TOTAL - 1);
    localparam logic [w_y-1:0] Y_LAST = w_y'(V_TOTAL - 1);
    localparam sync_t SYNC_IDLE = sync_idle(hsync_pol, vsync_pol);

    logic               tick;
    logic               pixel_ce;
    logic               pixel_clk;

    logic [w_x-1:0]     x_q;
    logic [w_x-1:0]     x_d;
    logic [w_y-1:0]     y_q;
    logic [w_y-1:0]     y_d;
    logic               line_start_q;
    logic               line_start_d;
    logic               frame_start_q;
    logic               frame_start_d;
    logic [w_frame-1:0] frame_count_q;
    logic [w_frame-1:0] frame_count_d;
    sync_t              sync_q;
    sync_t              sync_d;
    logic               h_act;
    logic               v_act;

    pixel_ce_gen #(
        .clk_mhz   (clk_mhz),
        .pixel_mhz (pixel_mhz)
    ) u_pixel_ce_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_o      (tick),
        .pixel_ce_o  (pixel_ce),
        .pixel_clk_o (pixel_clk)
    );

    // Regions are decoded from the new x/y so they line up with the counters.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        sync_d        = sync_q;
        h_act         = 1'b0;
        v_act         = 1'b0;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + w_y'(1);
            end else begin
                x_d = x_q + w_x'(1);
            end
            h_act = (int'(x_d) >= HS_START) && (int'(x_d) < HS_STOP);
            v_act = (int'(y_d) >= VS_START) && (int'(y_d) < VS_STOP);
            sync_d.hsync      = sync_level(h_act, hsync_pol);
            sync_d.vsync      = sync_level(v_act, vsync_pol);
            sync_d.display_on = (int'(x_d) < h_active) && (int'(y_d) < v_active);
            line_start_d  = (x_d == '0);
            frame_start_d = (x_d == '0) && (y_d == '0);
            if (frame_start_d) begin
                frame_count_d = frame_count_q + w_frame'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '1;
            sync_q        <= SYNC_IDLE;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            sync_q        <= sync_d;
        end
    end

    // Optional pixel-enabled delay on sync/DE only, matching the RGB pipeline.
    sync_t sync_tap [0:sync_delay];
    assign sync_tap[0] = sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < sync_delay; gi++) begin : g_sync_dly
            sync_t stage_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q <= SYNC_IDLE;
                end else if (tick) begin
                    stage_q <= sync_tap[gi];
                end
            end
            assign sync_tap[gi+1] = stage_q;
        end
    endgenerate

    assign vid_o.pixel_ce    = pixel_ce;
    assign vid_o.pixel_clk   = pixel_clk;
    assign vid_o.x           = x_q;
    assign vid_o.y           = y_q;
    assign vid_o.hsync       = sync_tap[sync_delay].hsync;
    assign vid_o.vsync       = sync_tap[sync_delay].vsync;
    assign vid_o.display_on  = sync_tap[sync_delay].display_on;
    assign vid_o.line_start  = line_start_q;
    assign vid_o.frame_start = frame_start_q;
    assign vid_o.frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 at 125/25, a tiny raster with active-high
// syncs at equal clocks, and 640x480 with a two-stage sync delay.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic rst_c_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // reference position for DUT A
    int ax = 0;
    int ay = 0;

    video_timing_gen_if #(.w_x(10), .w_y(10), .w_frame(8)) va ();
    video_timing_gen_if #(.w_x(4),  .w_y(4),  .w_frame(8)) vb ();
    video_timing_gen_if #(.w_x(10), .w_y(10), .w_frame(8)) vc ();

    video_timing_gen u_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .vid_o (va)
    );

    // 16x12 raster: hsync x 10..12, vsync y 8..9, active 8x6
    video_timing_gen #(
        .clk_mhz(25), .pixel_mhz(25),
        .h_active(8), .h_front(2), .h_sync(3), .h_back(3),
        .v_active(6), .v_front(2), .v_sync(2), .v_back(2),
        .hsync_pol(1), .vsync_pol(1)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .vid_o (vb)
    );

    video_timing_gen #(
        .clk_mhz(25), .pixel_mhz(25), .sync_delay(2)
    ) u_c (
        .clk   (clk),
        .rst_n (rst_c_n),
        .vid_o (vc)
    );

    task automatic test_reset();
        logic exp_pclk;
        @(negedge clk);
        rst_a_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b1;
        n_cmp++; if (va.x !== 10'd799) begin n_bad++; $display("FAIL reset_x got %0d want 799", va.x); end
        n_cmp++; if (va.y !== 10'd524) begin n_bad++; $display("FAIL reset_y got %0d want 524", va.y); end
        n_cmp++; if (va.display_on !== 1'b0) begin n_bad++; $display("FAIL reset_de got %b want 0", va.display_on); end
        n_cmp++; if (va.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", va.hsync); end
        n_cmp++; if (va.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", va.vsync); end
        n_cmp++; if (va.frame_count !== 8'd255) begin n_bad++; $display("FAIL reset_fc got %0d want 255", va.frame_count); end
        n_cmp++; if (va.pixel_ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce got %b want 0", va.pixel_ce); end
        n_cmp++; if (va.pixel_clk !== 1'b1) begin n_bad++; $display("FAIL reset_pclk got %b want 1", va.pixel_clk); end
        n_cmp++; if (va.line_start !== 1'b0 || va.frame_start !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobes got ls=%b fs=%b want 0 0", va.line_start, va.frame_start); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); @(negedge clk);
            exp_pclk = (k <= 2);
            n_cmp++; if (va.pixel_ce !== 1'b0) begin n_bad++; $display("FAIL early_ce clk %0d got %b want 0", k, va.pixel_ce); end
            n_cmp++; if (va.pixel_clk !== exp_pclk) begin n_bad++; $display("FAIL early_pclk clk %0d got %b want %b", k, va.pixel_clk, exp_pclk); end
        end
        @(posedge clk); @(negedge clk);
        ax = 0; ay = 0;
        n_cmp++; if (va.pixel_ce !== 1'b1) begin n_bad++; $display("FAIL first_ce got %b want 1", va.pixel_ce); end
        n_cmp++; if (va.x !== 10'd0 || va.y !== 10'd0) begin n_bad++; $display("FAIL first_xy got (%0d,%0d) want (0,0)", va.x, va.y); end
        n_cmp++; if (va.display_on !== 1'b1) begin n_bad++; $display("FAIL first_de got %b want 1", va.display_on); end
        n_cmp++; if (va.line_start !== 1'b1 || va.frame_start !== 1'b1) begin
            n_bad++; $display("FAIL first_strobes got ls=%b fs=%b want 1 1", va.line_start, va.frame_start); end
        n_cmp++; if (va.frame_count !== 8'd0) begin n_bad++; $display("FAIL first_fc got %0d want 0", va.frame_count); end
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_bad);
    endtask

    task automatic test_cadence();
        int ce_cnt = 0;
        int hi_cnt = 0;
        int ph;
        logic exp_ce;
        logic exp_pclk;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); @(negedge clk);
            ph = c % 5;
            exp_ce   = (ph == 0);
            exp_pclk = (ph < 3);
            n_cmp++; if (va.pixel_ce !== exp_ce) begin n_bad++; $display("FAIL cadence_ce clk %0d got %b want %b", c, va.pixel_ce, exp_ce); end
            n_cmp++; if (va.pixel_clk !== exp_pclk) begin n_bad++; $display("FAIL cadence_pclk clk %0d got %b want %b", c, va.pixel_clk, exp_pclk); end
            if (va.pixel_ce === 1'b1) begin
                ce_cnt++;
                ax++;
                n_cmp++; if (int'(va.x) != ax) begin n_bad++; $display("FAIL cadence_x got %0d want %0d", va.x, ax); end
            end
            if (va.pixel_clk === 1'b1) hi_cnt++;
        end
        n_cmp++; if (ce_cnt != 20) begin n_bad++; $display("FAIL cadence_count got %0d want 20", ce_cnt); end
        n_cmp++; if (hi_cnt != 60) begin n_bad++; $display("FAIL cadence_pclk_high got %0d want 60", hi_cnt); end
        $display("test_cadence done: ce=%0d pclk_high=%0d", ce_cnt, hi_cnt);
    endtask

    task automatic test_line();
        int cyc = 0;
        int hs_low = 0;
        bit done = 0;
        logic exp_hs, exp_de, exp_ls, exp_fs;
        while (!done && cyc < 5000) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (va.pixel_ce === 1'b1) begin
                if (ax == 799) begin ax = 0; ay = ay + 1; end else ax = ax + 1;
                exp_hs = !(ax >= 656 && ax < 752);
                exp_de = (ax < 640) && (ay < 480);
                exp_ls = (ax == 0);
                exp_fs = (ax == 0) && (ay == 0);
                n_cmp++; if (int'(va.x) != ax || int'(va.y) != ay) begin
                    n_bad++; $display("FAIL line_xy got (%0d,%0d) want (%0d,%0d)", va.x, va.y, ax, ay); end
                n_cmp++; if (va.hsync !== exp_hs) begin n_bad++; $display("FAIL line_hsync x=%0d got %b want %b", ax, va.hsync, exp_hs); end
                n_cmp++; if (va.display_on !== exp_de) begin n_bad++; $display("FAIL line_de x=%0d got %b want %b", ax, va.display_on, exp_de); end
                n_cmp++; if (va.line_start !== exp_ls || va.frame_start !== exp_fs) begin
                    n_bad++; $display("FAIL line_strobes x=%0d got ls=%b fs=%b want %b %b", ax, va.line_start, va.frame_start, exp_ls, exp_fs); end
                if (va.hsync === 1'b0) hs_low++;
                if (ax == 0) done = 1;
            end else begin
                n_cmp++; if (va.line_start !== 1'b0 || va.frame_start !== 1'b0) begin
                    n_bad++; $display("FAIL line_pulse_idle got ls=%b fs=%b want 0 0", va.line_start, va.frame_start); end
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL line_timeout got %0d cycles want wrap within 5000", cyc); end
        n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL line_hsync_width got %0d want 96", hs_low); end
        $display("test_line done: cycles=%0d hsync_low=%0d", cyc, hs_low);
    endtask

    task automatic test_frame();
        int ex = 15;
        int ey = 11;
        int efc = 255;
        int fs_cnt = 0;
        logic exp_hs, exp_vs, exp_de, exp_ls, exp_fs;
        @(negedge clk);
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b_n = 1'b1;
        n_cmp++; if (vb.x !== 4'd15 || vb.y !== 4'd11) begin n_bad++; $display("FAIL small_reset_xy got (%0d,%0d) want (15,11)", vb.x, vb.y); end
        n_cmp++; if (vb.hsync !== 1'b0 || vb.vsync !== 1'b0) begin
            n_bad++; $display("FAIL small_reset_sync got hs=%b vs=%b want 0 0", vb.hsync, vb.vsync); end
        n_cmp++; if (vb.frame_count !== 8'd255) begin n_bad++; $display("FAIL small_reset_fc got %0d want 255", vb.frame_count); end
        for (int c = 1; c <= 2 * 192 + 4; c++) begin
            @(posedge clk); @(negedge clk);
            ex = (ex + 1) % 16;
            if (ex == 0) ey = (ey + 1) % 12;
            if (ex == 0 && ey == 0) efc = (efc + 1) % 256;
            exp_hs = (ex >= 10 && ex < 13);
            exp_vs = (ey >= 8 && ey < 10);
            exp_de = (ex < 8) && (ey < 6);
            exp_ls = (ex == 0);
            exp_fs = (ex == 0) && (ey == 0);
            n_cmp++; if (vb.pixel_ce !== 1'b1 || vb.pixel_clk !== 1'b1) begin
                n_bad++; $display("FAIL small_ce clk %0d got ce=%b pclk=%b want 1 1", c, vb.pixel_ce, vb.pixel_clk); end
            n_cmp++; if (int'(vb.x) != ex || int'(vb.y) != ey) begin
                n_bad++; $display("FAIL small_xy got (%0d,%0d) want (%0d,%0d)", vb.x, vb.y, ex, ey); end
            n_cmp++; if (vb.hsync !== exp_hs || vb.vsync !== exp_vs) begin
                n_bad++; $display("FAIL small_sync (%0d,%0d) got hs=%b vs=%b want %b %b", ex, ey, vb.hsync, vb.vsync, exp_hs, exp_vs); end
            n_cmp++; if (vb.display_on !== exp_de) begin n_bad++; $display("FAIL small_de (%0d,%0d) got %b want %b", ex, ey, vb.display_on, exp_de); end
            n_cmp++; if (vb.line_start !== exp_ls || vb.frame_start !== exp_fs) begin
                n_bad++; $display("FAIL small_strobes (%0d,%0d) got ls=%b fs=%b want %b %b", ex, ey, vb.line_start, vb.frame_start, exp_ls, exp_fs); end
            n_cmp++; if (int'(vb.frame_count) != efc) begin n_bad++; $display("FAIL small_fc got %0d want %0d", vb.frame_count, efc); end
            if (vb.frame_start === 1'b1) fs_cnt++;
        end
        n_cmp++; if (fs_cnt != 3) begin n_bad++; $display("FAIL small_frame_starts got %0d want 3", fs_cnt); end
        $display("test_frame done: frame_starts=%0d", fs_cnt);
    endtask

    task automatic test_midframe_reset();
        int cyc = 0;
        bit found = 0;
        while (!found && cyc < 400) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (vb.x === 4'd5 && vb.y === 4'd3) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL midreset_wait got timeout after %0d want (5,3)", cyc); end
        rst_b_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_b_n = 1'b1;
        n_cmp++; if (vb.x !== 4'd15 || vb.y !== 4'd11) begin n_bad++; $display("FAIL midreset_xy got (%0d,%0d) want (15,11)", vb.x, vb.y); end
        n_cmp++; if (vb.hsync !== 1'b0 || vb.vsync !== 1'b0 || vb.display_on !== 1'b0) begin
            n_bad++; $display("FAIL midreset_sync got hs=%b vs=%b de=%b want 0 0 0", vb.hsync, vb.vsync, vb.display_on); end
        n_cmp++; if (vb.pixel_ce !== 1'b0 || vb.line_start !== 1'b0 || vb.frame_start !== 1'b0) begin
            n_bad++; $display("FAIL midreset_pulses got ce=%b ls=%b fs=%b want 0 0 0", vb.pixel_ce, vb.line_start, vb.frame_start); end
        n_cmp++; if (vb.frame_count !== 8'd255 || vb.pixel_clk !== 1'b1) begin
            n_bad++; $display("FAIL midreset_fc got fc=%0d pclk=%b want 255 1", vb.frame_count, vb.pixel_clk); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (vb.x !== 4'd0 || vb.y !== 4'd0 || vb.pixel_ce !== 1'b1) begin
            n_bad++; $display("FAIL midreset_restart got (%0d,%0d) ce=%b want (0,0) 1", vb.x, vb.y, vb.pixel_ce); end
        n_cmp++; if (vb.frame_start !== 1'b1 || vb.line_start !== 1'b1 || vb.frame_count !== 8'd0) begin
            n_bad++; $display("FAIL midreset_strobes got fs=%b ls=%b fc=%0d want 1 1 0", vb.frame_start, vb.line_start, vb.frame_count); end
        n_cmp++; if (vb.display_on !== 1'b1) begin n_bad++; $display("FAIL midreset_de got %b want 1", vb.display_on); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (vb.x !== 4'd1 || vb.frame_start !== 1'b0 || vb.line_start !== 1'b0) begin
            n_bad++; $display("FAIL midreset_next got x=%0d fs=%b ls=%b want 1 0 0", vb.x, vb.frame_start, vb.line_start); end
        $display("test_midframe_reset done: waited %0d cycles", cyc);
    endtask

    task automatic test_delay();
        logic exp_de, exp_hs;
        @(negedge clk);
        rst_c_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_c_n = 1'b1;
        n_cmp++; if (vc.display_on !== 1'b0 || vc.hsync !== 1'b1 || vc.vsync !== 1'b1) begin
            n_bad++; $display("FAIL delay_reset got de=%b hs=%b vs=%b want 0 1 1", vc.display_on, vc.hsync, vc.vsync); end
        for (int ex = 0; ex < 800; ex++) begin
            @(posedge clk); @(negedge clk);
            exp_de = (ex >= 2) && (ex < 642);
            exp_hs = !(ex >= 658 && ex < 754);
            n_cmp++; if (int'(vc.x) != ex || vc.y !== 10'd0) begin
                n_bad++; $display("FAIL delay_xy got (%0d,%0d) want (%0d,0)", vc.x, vc.y, ex); end
            n_cmp++; if (vc.display_on !== exp_de) begin n_bad++; $display("FAIL delay_de x=%0d got %b want %b", ex, vc.display_on, exp_de); end
            n_cmp++; if (vc.hsync !== exp_hs || vc.vsync !== 1'b1) begin
                n_bad++; $display("FAIL delay_sync x=%0d got hs=%b vs=%b want %b 1", ex, vc.hsync, vc.vsync, exp_hs); end
            n_cmp++; if (vc.line_start !== (ex == 0)) begin n_bad++; $display("FAIL delay_ls x=%0d got %b want %b", ex, vc.line_start, (ex == 0)); end
        end
        $display("test_delay done: one line checked");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cadence();
        test_line();
        test_frame();
        test_midframe_reset();
        test_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
